// File: rtl/voice_pkg.sv
// Voice recorder shared types and rate constants.
// Imported by the controller and the playback unpacker.
package voice_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REC,
    PLAY_FETCH,
    PLAY_WAIT,
    PLAY_OUT
  } ctrl_state_t;

  localparam int SAMPLE_W         = 8;
  localparam int SAMPLES_PER_WORD = 4;
  localparam int SAMPLE_FREQ      = 10000;
  localparam int CLK_FREQ         = 2_400_000;
  localparam int PLAY_DIV         = CLK_FREQ / SAMPLE_FREQ;

endpackage

// File: rtl/voice_unpacker.sv
// Holds one fetched RAM word and steps through its samples,
// oldest (most significant) sample first.
module voice_unpacker #(
  parameter int SAMPLE_W = voice_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [voice_pkg::SAMPLES_PER_WORD*SAMPLE_W-1:0] word,
  input  logic                advance,
  output logic [SAMPLE_W-1:0] sample,
  output logic [1:0]          slot
);
  import voice_pkg::*;

  localparam int WORD_W = SAMPLES_PER_WORD * SAMPLE_W;

  logic [WORD_W-1:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      slot   <= '0;
    end else if (load) begin
      hold_q <= word;
      slot   <= '0;
    end else if (advance) begin
      slot <= slot + 2'd1;
    end
  end

  always_comb begin
    sample = '0;
    for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
      if (slot == 2'(i))
        sample = hold_q[WORD_W-1-i*SAMPLE_W -: SAMPLE_W];
    end
  end

endmodule

// File: rtl/voice_rec_ctrl.sv
// Record/playback sequencer sharing one single-port sample RAM
// between the PDM sampler and the paced audio output path.
module voice_rec_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int SAMPLE_W = voice_pkg::SAMPLE_W,
  parameter int PLAY_DIV = voice_pkg::PLAY_DIV,
  parameter int RD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rec_start,
  input  logic                  play_start,
  input  logic                  stop,
  output logic                  smp_count_en,
  input  logic [4*SAMPLE_W-1:0] smp_data,
  input  logic                  smp_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [4*SAMPLE_W-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [4*SAMPLE_W-1:0] mem_rdata,
  output logic [SAMPLE_W-1:0]   aud_sample,
  output logic                  aud_valid,
  input  logic                  aud_ready,
  output logic [ADDR_W:0]       rec_len,
  output logic                  busy
);
  import voice_pkg::*;

  localparam int PW = $clog2(PLAY_DIV);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [PW-1:0] PACE_TOP = PW'(PLAY_DIV - 1);
  localparam logic [LW-1:0] WAIT_TOP = LW'(RD_LAT - 1);

  ctrl_state_t state, state_n;

  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       rd_ptr;
  logic [PW-1:0]         pace_cnt;
  logic [LW-1:0]         wait_cnt;
  logic                  we_q;
  logic                  fin_q;
  logic [4*SAMPLE_W-1:0] wdata_q;
  logic                  playing;
  logic                  wr_last;
  logic                  is_last;
  logic                  hs;
  logic                  ld;
  logic                  adv;
  logic [1:0]            slot;
  logic [SAMPLE_W-1:0]   smp;

  assign playing = (state == PLAY_FETCH) ||
                   (state == PLAY_WAIT) ||
                   (state == PLAY_OUT);
  assign wr_last = we_q && (wr_ptr == LAST);
  assign is_last = (rd_ptr + ONE) == rec_len;

  assign aud_valid  = (state == PLAY_OUT) &&
                      (pace_cnt == PACE_TOP);
  assign hs         = aud_valid && aud_ready;
  assign aud_sample = aud_valid ? smp : '0;
  assign busy       = (state != IDLE);
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;
  assign mem_re     = (state == PLAY_FETCH);

  // A write can trail the REC exit by one cycle, so it owns the bus then
  always_comb begin
    mem_addr = '0;
    unique case (1'b1)
      we_q:    mem_addr = wr_ptr[ADDR_W-1:0];
      mem_re:  mem_addr = rd_ptr[ADDR_W-1:0];
      default: mem_addr = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        // fin_q holds off starts until rec_len reflects the last write
        if (!fin_q) begin
          if (rec_start)
            state_n = REC;
          else if (play_start && rec_len != '0)
            state_n = PLAY_FETCH;
        end
      end
      REC: begin
        if (stop || wr_last)
          state_n = IDLE;
      end
      PLAY_FETCH: begin
        state_n = stop ? IDLE : PLAY_WAIT;
      end
      PLAY_WAIT: begin
        if (stop) begin
          state_n = IDLE;
        end else if (wait_cnt == WAIT_TOP) begin
          ld      = 1'b1;
          state_n = PLAY_OUT;
        end
      end
      PLAY_OUT: begin
        if (stop) begin
          state_n = IDLE;
        end else if (hs) begin
          adv = 1'b1;
          if (slot == 2'd3)
            state_n = is_last ? IDLE : PLAY_FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      smp_count_en <= 1'b0;
      we_q         <= 1'b0;
      fin_q        <= 1'b0;
      wdata_q      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pace_cnt     <= '0;
      wait_cnt     <= '0;
      rec_len      <= '0;
    end else begin
      state        <= state_n;
      smp_count_en <= (state_n == REC);
      fin_q        <= (state == REC) && (state_n != REC);
      we_q         <= (state == REC) && smp_wr && !wr_last;
      if ((state == REC) && smp_wr)
        wdata_q <= smp_data;
      if ((state == IDLE) && (state_n == REC))
        wr_ptr <= '0;
      else if (we_q)
        wr_ptr <= wr_ptr + ONE;
      if (fin_q)
        rec_len <= wr_ptr + {ADDR_W'(0), we_q};
      wait_cnt <= (state == PLAY_WAIT) ? wait_cnt + LW'(1) : '0;
      if ((state == IDLE) && (state_n == PLAY_FETCH)) begin
        rd_ptr   <= '0;
        pace_cnt <= '0;
      end else if (playing) begin
        if (hs)
          pace_cnt <= '0;
        else if (pace_cnt != PACE_TOP)
          pace_cnt <= pace_cnt + PW'(1);
        if (hs && slot == 2'd3)
          rd_ptr <= rd_ptr + ONE;
      end
    end
  end

  voice_unpacker #(
    .SAMPLE_W(SAMPLE_W)
  ) u_unpack (
    .clk    (clk),
    .rst    (rst),
    .load   (ld),
    .word   (mem_rdata),
    .advance(adv),
    .sample (smp),
    .slot   (slot)
  );

endmodule
